// File: rtl/sd_pattern_tx.sv
// Serial pattern transmitter: shifts a captured parallel pattern out MSB-first,
// optionally repeating the frame with an idle gap between repetitions.
module sd_pattern_tx #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned REPEAT_W = 4,
  parameter int unsigned GAP_LEN  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    pattern,
  input  logic [REPEAT_W-1:0] repeat_cnt,
  output logic                o,
  output logic                o_valid,
  output logic                busy,
  output logic                done
);

  localparam int unsigned BIT_W    = $clog2(WIDTH);
  localparam int unsigned GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam int unsigned GAP_LAST = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [WIDTH-1:0]    copy_q, copy_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [REPEAT_W-1:0] frame_q, frame_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                o_q, o_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state logic; o/o_valid/busy/done are computed for the cycle being entered.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    copy_d  = copy_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    gap_d   = gap_q;
    o_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          copy_d  = pattern;
          shift_d = {pattern[WIDTH-2:0], 1'b0};
          frame_d = repeat_cnt;
          bit_d   = '0;
          gap_d   = '0;
          o_d     = pattern[WIDTH-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          bit_d   = '0;
          frame_d = '0;
          gap_d   = '0;
        end else if (bit_q == BIT_LAST) begin
          bit_d = '0;
          if (frame_q != '0) begin
            frame_d = frame_q - 1'b1;
            busy_d  = 1'b1;
            if (GAP_LEN == 0) begin
              shift_d = {copy_q[WIDTH-2:0], 1'b0};
              o_d     = copy_q[WIDTH-1];
              valid_d = 1'b1;
            end else begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          o_d     = shift_q[WIDTH-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          bit_d   = bit_q + 1'b1;
        end
      end

      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          bit_d   = '0;
          frame_d = '0;
          gap_d   = '0;
        end else begin
          busy_d = 1'b1;
          if (gap_q == GAP_W'(GAP_LAST)) begin
            state_d = S_SHIFT;
            gap_d   = '0;
            bit_d   = '0;
            shift_d = {copy_q[WIDTH-2:0], 1'b0};
            o_d     = copy_q[WIDTH-1];
            valid_d = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        bit_d   = '0;
        frame_d = '0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      copy_q  <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      gap_q   <= '0;
      o_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      copy_q  <= copy_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      gap_q   <= gap_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o       = o_q;
  assign o_valid = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sd_pattern_tx.sv
// Directed bench for sd_pattern_tx: one instance with back-to-back frames,
// one with a 3-cycle inter-frame gap.
module tb_sd_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] repeat_cnt = '0;
  logic       start3 = 1'b0, abort3 = 1'b0;
  logic [7:0] pattern3 = '0;
  logic [3:0] repeat3 = '0;
  logic       o0, v0, b0, d0;
  logic       o3, v3, b3, d3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sd_pattern_tx #(.WIDTH(8), .REPEAT_W(4), .GAP_LEN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pattern(pattern), .repeat_cnt(repeat_cnt),
    .o(o0), .o_valid(v0), .busy(b0), .done(d0)
  );

  sd_pattern_tx #(.WIDTH(8), .REPEAT_W(4), .GAP_LEN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .pattern(pattern3), .repeat_cnt(repeat3),
    .o(o3), .o_valid(v3), .busy(b3), .done(d3)
  );

  // Observed outputs packed as {o, o_valid, busy, done}.
  function automatic logic [3:0] obs(input bit sel);
    return sel ? {o3, v3, b3, d3} : {o0, v0, b0, d0};
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed {o,vld,busy,done}=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one transfer in cycle 0 and check every cycle through done and one idle cycle.
  task automatic xfer(input bit sel, input logic [7:0] pat, input logic [3:0] rep,
                      input string tag);
    int gap;
    gap = sel ? 3 : 0;
    if (sel) begin start3 = 1'b1; pattern3 = pat; repeat3 = rep; end
    else     begin start  = 1'b1; pattern  = pat; repeat_cnt = rep; end
    for (int f = 0; f <= int'(rep); f++) begin
      for (int b = 0; b < 8; b++) begin
        step();
        if (f == 0 && b == 0) begin
          start = 1'b0; start3 = 1'b0;
          pattern = ~pat; pattern3 = ~pat; repeat_cnt = 4'h0; repeat3 = 4'h0;
        end
        chk($sformatf("%s f%0d b%0d", tag, f, b), obs(sel), {pat[7-b], 3'b110});
      end
      if (f < int'(rep)) begin
        for (int g = 0; g < gap; g++) begin
          step();
          chk($sformatf("%s gap f%0d g%0d", tag, f, g), obs(sel), 4'b0010);
        end
      end
    end
    step();
    chk({tag, " done"}, obs(sel), 4'b0001);
    step();
    chk({tag, " idle"}, obs(sel), 4'b0000);
  endtask

  initial begin
    logic [7:0] p;

    // Reset state
    repeat (2) step();
    chk("reset dut0", obs(1'b0), 4'b0000);
    chk("reset dut3", obs(1'b1), 4'b0000);
    rst_n = 1'b1;
    step();
    chk("idle after reset", obs(1'b0), 4'b0000);

    // Single frame, then repeated frames with and without gap
    xfer(1'b0, 8'b1001_0110, 4'd0, "t1");
    xfer(1'b0, 8'hA5, 4'd2, "t2 nogap");
    xfer(1'b1, 8'hA5, 4'd2, "t2 gap3");

    // Start pulses while busy are ignored
    p = 8'h3C;
    start = 1'b1; pattern = p; repeat_cnt = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) pattern = 8'hFF;
      chk($sformatf("t3 b%0d", k - 1), obs(1'b0), {p[8-k], 3'b110});
      start = (k == 3 || k == 5) ? 1'b1 : 1'b0;
    end
    step();
    chk("t3 done", obs(1'b0), 4'b0001);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t3 quiet%0d", k), obs(1'b0), 4'b0000);
    end

    // Start held high: re-accepted in the done cycle
    p = 8'hC3;
    start = 1'b1; pattern = p; repeat_cnt = 4'd0;
    for (int t = 0; t < 3; t++) begin
      for (int k = 1; k <= 8; k++) begin
        step();
        chk($sformatf("t4 x%0d b%0d", t, k - 1), obs(1'b0), {p[8-k], 3'b110});
      end
      step();
      chk($sformatf("t4 x%0d done", t), obs(1'b0), 4'b0001);
      if (t == 2) start = 1'b0;
    end
    step();
    chk("t4 idle", obs(1'b0), 4'b0000);

    // Abort at 4th bit of 2nd frame
    p = 8'h5A;
    start = 1'b1; pattern = p; repeat_cnt = 4'd3;
    for (int k = 1; k <= 12; k++) begin
      step();
      start = 1'b0;
      chk($sformatf("t5 c%0d", k), obs(1'b0), {p[7-((k-1)%8)], 3'b110});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5 aborted", obs(1'b0), 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t5 quiet%0d", k), obs(1'b0), 4'b0000);
    end
    abort = 1'b1;
    step();
    chk("t5 abort idle", obs(1'b0), 4'b0000);
    abort = 1'b0;
    xfer(1'b0, 8'h81, 4'd0, "t5 after");

    // Asynchronous reset mid-frame
    p = 8'hE7;
    start = 1'b1; pattern = p; repeat_cnt = 4'd1;
    for (int k = 1; k <= 4; k++) begin
      step();
      start = 1'b0;
      chk($sformatf("t6 c%0d", k), obs(1'b0), {p[8-k], 3'b110});
    end
    #2 rst_n = 1'b0;
    #1 chk("t6 async reset", obs(1'b0), 4'b0000);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6 post-reset%0d", k), obs(1'b0), 4'b0000);
    end

    // Repeat count all ones: 16 frames
    xfer(1'b0, 8'h6D, 4'hF, "t6 rep15");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sd_pattern_tx.md
Name: sd_pattern_tx

Overview:
Serial pattern transmitter that produces the single-bit stream consumed by the team's serial sequence detectors. A parallel pattern is loaded on a start strobe and shifted out MSB-first, one bit per clock. It can repeat the frame N times, with an optional idle gap between frames. Used as the stimulus source for detector blocks on the board and in system benches.

Parameters:
WIDTH, 8, pattern length in bits (>=2).
REPEAT_W, 4, width of the repeat-count input.
GAP_LEN, 0, idle cycles inserted between repeated frames (0 = back-to-back).

Ports:
clk  input  1  single system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  start request, sampled only in IDLE.
abort  input  1  synchronous abort, sampled in any non-IDLE state.
pattern  input  WIDTH  frame to send, captured on accepted start.
repeat_cnt  input  REPEAT_W  extra frames to send, captured on accepted start (0 = one frame).
o  output  1  serial data, registered.
o_valid  output  1  high while o carries a pattern bit, registered.
busy  output  1  high from the cycle after an accepted start until the transfer ends.
done  output  1  one-cycle pulse after the last bit of the last frame.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; o=0, o_valid=0, busy=0, done=0; shift register, bit counter, frame counter and gap counter all cleared. This takes effect immediately, even mid-frame. No done is issued for an abandoned transfer.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, SHIFT, GAP.
- IDLE: o=0, o_valid=0, busy=0.
  - start=1 captures pattern into the shift register and a pattern copy, and captures repeat_cnt into the frame counter.
  - The next cycle is SHIFT, with o=pattern[WIDTH-1], o_valid=1, busy=1. Latency from start to first bit is 1 cycle.
- SHIFT: lasts WIDTH cycles per frame. Bit k of the frame (k=0..WIDTH-1) drives o=pattern[WIDTH-1-k]. The bit counter counts 0..WIDTH-1.
  - After the last bit with frame counter > 0: decrement the frame counter.
    - GAP_LEN>0: go to GAP.
    - GAP_LEN=0: reload the shift register from the pattern copy. The first bit of the next frame appears in the very next cycle, with o_valid staying high continuously.
  - After the last bit with frame counter = 0: go to IDLE. done=1 and busy=0 for exactly that one cycle; o=0, o_valid=0.
- GAP: GAP_LEN cycles with o=0, o_valid=0, busy=1. Then reload the pattern copy and go to SHIFT.
- Total cycles from the first bit to done = (repeat_cnt+1)*WIDTH + repeat_cnt*GAP_LEN.
- start while busy (SHIFT/GAP) is ignored. Changes on pattern/repeat_cnt while busy do not affect the transfer in progress.
- start asserted in the same cycle done is high is accepted, because the state is IDLE. The next transfer's first bit follows 1 cycle later.
- abort=1 in SHIFT or GAP: next cycle IDLE, o=0, o_valid=0, busy=0, done=0. Counters are cleared. abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Frame counter wrap: repeat_cnt = all ones sends 2^REPEAT_W frames. The counter never underflows.
- Illegal/unused state encodings recover to IDLE with outputs deasserted.

Test Plan:
1. Reset, then a one-cycle start with pattern=8'b1001_0110, repeat_cnt=0 -> o_valid high cycles 1..8 after start with o=1,0,0,1,0,1,1,0; done pulse at cycle 9; busy high cycles 1..8.
2. pattern=8'hA5, repeat_cnt=2, GAP_LEN=0 -> 24 contiguous valid bits (A5 A5 A5, MSB first); done at cycle 25. With GAP_LEN=3 -> three 8-bit frames separated by 3 cycles of o_valid=0; done at cycle 31.
3. start pulsed again at cycles 3 and 5 with pattern=8'hFF mid-transfer of 8'h3C -> the stream is exactly 8'h3C, a single done, and no second transfer.
4. start held high continuously with pattern=8'hC3, repeat_cnt=0 -> done at cycle 9 coincides with re-acceptance; the next frame's first bit appears at cycle 10. Repeat for 3 transfers.
5. abort at the 4th bit of the 2nd frame (repeat_cnt=3) -> next cycle o=0, o_valid=0, busy=0, no done; a subsequent start transmits normally.
6. rst_n dropped asynchronously mid-bit during SHIFT -> outputs go to 0 before the next clock edge; after release the block is idle until start. Also check repeat_cnt=4'hF sends 16 frames (128 bits).
